demux1x3_tdm: RTL and testbench

DEMUX1X3_TDM -- requirements
Module: demux1x3_tdm

---
 rtl/demux1x3_tdm.sv | 119 +++++++++++
 tb/tb_demux1x3_tdm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1x3_tdm.sv
// 1:3 time-division demultiplexer: slots 0..2 of each frame (slot 0 marked by sof) are
// collected and presented together on dout0..dout2. Optional err_cnt port under DEMUX_ERR_CNT_EN.
module demux1x3_tdm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic             frame_vld,
  output logic [1:0]       sel,
  output logic             sync_err
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] EXP1 = 2'd1;
  localparam logic [1:0] EXP2 = 2'd2;
  localparam logic [1:0] EXP0 = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] shadow0;
  logic [WIDTH-1:0] shadow1;
  logic             err_event;

  // Framing violation: sof inside a frame, or a non-sof slot where slot 0 was due.
  always_comb begin
    err_event = 1'b0;
    if (din_vld) begin
      unique case (state)
        EXP1, EXP2: err_event = sof;
        EXP0:       err_event = ~sof;
        default:    err_event = 1'b0;
      endcase
    end
  end

  always_comb begin
    sel = 2'd0;
    unique case (state)
      EXP1:    sel = 2'd1;
      EXP2:    sel = 2'd2;
      default: sel = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      shadow0   <= '0;
      shadow1   <= '0;
      dout0     <= '0;
      dout1     <= '0;
      dout2     <= '0;
      frame_vld <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      frame_vld <= 1'b0;
      sync_err  <= err_event;
      if (din_vld) begin
        unique case (state)
          HUNT: begin
            if (sof) begin
              shadow0 <= din;
              state   <= EXP1;
            end
          end
          EXP1: begin
            if (sof) begin
              shadow0 <= din;
            end else begin
              shadow1 <= din;
              state   <= EXP2;
            end
          end
          EXP2: begin
            if (sof) begin
              shadow0 <= din;
              state   <= EXP1;
            end else begin
              dout0     <= shadow0;
              dout1     <= shadow1;
              dout2     <= din;
              frame_vld <= 1'b1;
              state     <= EXP0;
            end
          end
          EXP0: begin
            if (sof) begin
              shadow0 <= din;
              state   <= EXP1;
            end else begin
              state <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef DEMUX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_event && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1x3_tdm.sv
// Directed self-checking bench for demux1x3_tdm; err_cnt checks are built when
// DEMUX_ERR_CNT_EN is defined.
module tb_demux1x3_tdm;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_vld;
  logic       sof;
  logic [7:0] dout0;
  logic [7:0] dout1;
  logic [7:0] dout2;
  logic       frame_vld;
  logic [1:0] sel;
  logic       sync_err;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  demux1x3_tdm #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .sof       (sof),
    .dout0     (dout0),
    .dout1     (dout1),
    .dout2     (dout2),
    .frame_vld (frame_vld),
    .sel       (sel),
    .sync_err  (sync_err)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns after the next rising edge.
  task automatic cyc(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    din_vld = v;
    sof     = s;
    din     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din_vld = 1'b0; sof = 1'b0; din = 8'h00;
    #12;
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    total++; if (dout0 !== 8'h00) begin bad++; $display("FAIL reset_dout0 got=%h exp=00", dout0); end
    total++; if (dout1 !== 8'h00) begin bad++; $display("FAIL reset_dout1 got=%h exp=00", dout1); end
    total++; if (dout2 !== 8'h00) begin bad++; $display("FAIL reset_dout2 got=%h exp=00", dout2); end
    total++; if (frame_vld !== 1'b0) begin bad++; $display("FAIL reset_frame_vld got=%b exp=0", frame_vld); end
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL reset_sync_err got=%b exp=0", sync_err); end
`ifdef DEMUX_ERR_CNT_EN
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    cyc(1'b1, 1'b1, 8'h11);
    total++; if (sel !== 2'd1) begin bad++; $display("FAIL single_sel1 got=%0d exp=1", sel); end
    total++; if (frame_vld !== 1'b0) begin bad++; $display("FAIL single_early_fv got=%b exp=0", frame_vld); end
    cyc(1'b1, 1'b0, 8'h22);
    total++; if (sel !== 2'd2) begin bad++; $display("FAIL single_sel2 got=%0d exp=2", sel); end
    cyc(1'b1, 1'b0, 8'h33);
    total++; if (frame_vld !== 1'b1) begin bad++; $display("FAIL single_fv got=%b exp=1", frame_vld); end
    total++; if ({dout0, dout1, dout2} !== 24'h112233) begin bad++; $display("FAIL single_dout got=%h exp=112233", {dout0, dout1, dout2}); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL single_sel0 got=%0d exp=0", sel); end
    cyc(1'b0, 1'b0, 8'h00);
    total++; if (frame_vld !== 1'b0) begin bad++; $display("FAIL single_fv_pulse got=%b exp=0", frame_vld); end
    total++; if ({dout0, dout1, dout2} !== 24'h112233) begin bad++; $display("FAIL single_hold got=%h exp=112233", {dout0, dout1, dout2}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] data [6];
    int first = -1;
    int second = -1;
    int pulses = 0;
    data = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, (i % 3) == 0, data[i]);
      if (frame_vld === 1'b1) begin
        pulses++;
        if (first < 0) first = i; else second = i;
        if (i == 2) begin
          total++; if ({dout0, dout1, dout2} !== 24'hA1A2A3) begin bad++; $display("FAIL b2b_first got=%h exp=a1a2a3", {dout0, dout1, dout2}); end
        end
      end
      total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL b2b_no_err slot=%0d got=%b exp=0", i, sync_err); end
    end
    total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    total++; if (second - first != 3) begin bad++; $display("FAIL b2b_spacing got=%0d exp=3", second - first); end
    total++; if ({dout0, dout1, dout2} !== 24'hB1B2B3) begin bad++; $display("FAIL b2b_second got=%h exp=b1b2b3", {dout0, dout1, dout2}); end
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_gaps();
    cyc(1'b1, 1'b1, 8'h01);
    total++; if (sel !== 2'd1) begin bad++; $display("FAIL gap_sel1 got=%0d exp=1", sel); end
    // Gap cycles carry sof=1 and junk data that must be ignored.
    for (int g = 0; g < 2; g++) begin
      cyc(1'b0, 1'b1, 8'hEE);
      total++; if (sel !== 2'd1) begin bad++; $display("FAIL gap_hold1 got=%0d exp=1", sel); end
      total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL gap_err1 got=%b exp=0", sync_err); end
    end
    cyc(1'b1, 1'b0, 8'h02);
    total++; if (sel !== 2'd2) begin bad++; $display("FAIL gap_sel2 got=%0d exp=2", sel); end
    for (int g = 0; g < 2; g++) begin
      cyc(1'b0, 1'b0, 8'hDD);
      total++; if (sel !== 2'd2) begin bad++; $display("FAIL gap_hold2 got=%0d exp=2", sel); end
      total++; if (frame_vld !== 1'b0) begin bad++; $display("FAIL gap_fv got=%b exp=0", frame_vld); end
    end
    cyc(1'b1, 1'b0, 8'h03);
    total++; if (frame_vld !== 1'b1) begin bad++; $display("FAIL gap_fv_done got=%b exp=1", frame_vld); end
    total++; if ({dout0, dout1, dout2} !== 24'h010203) begin bad++; $display("FAIL gap_dout got=%h exp=010203", {dout0, dout1, dout2}); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL gap_sel0 got=%0d exp=0", sel); end
  endtask

  task automatic test_sof_error();
    cyc(1'b1, 1'b1, 8'h44);
    cyc(1'b1, 1'b0, 8'h45);
    cyc(1'b1, 1'b1, 8'h50);
    total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL soferr_pulse got=%b exp=1", sync_err); end
    total++; if (frame_vld !== 1'b0) begin bad++; $display("FAIL soferr_fv got=%b exp=0", frame_vld); end
    total++; if (sel !== 2'd1) begin bad++; $display("FAIL soferr_sel got=%0d exp=1", sel); end
    total++; if ({dout0, dout1, dout2} !== 24'h010203) begin bad++; $display("FAIL soferr_hold got=%h exp=010203", {dout0, dout1, dout2}); end
    cyc(1'b1, 1'b0, 8'h55);
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL soferr_one_cycle got=%b exp=0", sync_err); end
    cyc(1'b1, 1'b0, 8'h66);
    total++; if (frame_vld !== 1'b1) begin bad++; $display("FAIL soferr_fv_done got=%b exp=1", frame_vld); end
    total++; if ({dout0, dout1, dout2} !== 24'h505566) begin bad++; $display("FAIL soferr_dout got=%h exp=505566", {dout0, dout1, dout2}); end
  endtask

  task automatic test_exp0_error();
    cyc(1'b1, 1'b0, 8'h77);
    total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL exp0err_pulse got=%b exp=1", sync_err); end
    total++; if (frame_vld !== 1'b0) begin bad++; $display("FAIL exp0err_fv got=%b exp=0", frame_vld); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL exp0err_sel got=%0d exp=0", sel); end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 8'h78);
      total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL hunt_no_err got=%b exp=0", sync_err); end
      total++; if (sel !== 2'd0) begin bad++; $display("FAIL hunt_sel got=%0d exp=0", sel); end
    end
    total++; if ({dout0, dout1, dout2} !== 24'h505566) begin bad++; $display("FAIL hunt_hold got=%h exp=505566", {dout0, dout1, dout2}); end
    cyc(1'b1, 1'b1, 8'h81);
    total++; if (sel !== 2'd1) begin bad++; $display("FAIL hunt_relock got=%0d exp=1", sel); end
    cyc(1'b1, 1'b0, 8'h82);
    cyc(1'b1, 1'b0, 8'h83);
    total++; if ({frame_vld, dout0, dout1, dout2} !== 25'h1818283) begin bad++; $display("FAIL hunt_frame got=%h exp=1818283", {frame_vld, dout0, dout1, dout2}); end
`ifdef DEMUX_ERR_CNT_EN
    total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL errcnt_two got=%0d exp=2", err_cnt); end
    // Repeated sof slots while expecting slot 1 raise an error every cycle.
    cyc(1'b1, 1'b1, 8'h90);
    for (int k = 0; k < 300; k++) cyc(1'b1, 1'b1, 8'h90);
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL errcnt_sat got=%0d exp=255", err_cnt); end
    cyc(1'b1, 1'b0, 8'h91);
    cyc(1'b1, 1'b0, 8'h92);
`endif
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 1'b1, 8'h91);
    cyc(1'b1, 1'b0, 8'h92);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({dout0, dout1, dout2} !== 24'h0) begin bad++; $display("FAIL arst_dout got=%h exp=000000", {dout0, dout1, dout2}); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL arst_sel got=%0d exp=0", sel); end
    total++; if ({frame_vld, sync_err} !== 2'b00) begin bad++; $display("FAIL arst_pulses got=%b exp=00", {frame_vld, sync_err}); end
`ifdef DEMUX_ERR_CNT_EN
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL arst_err_cnt got=%0d exp=0", err_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 8'hA0 + 8'(k));
      total++; if ({sel, frame_vld, sync_err} !== 4'b0000) begin bad++; $display("FAIL arst_ignore got=%b exp=0000", {sel, frame_vld, sync_err}); end
    end
    cyc(1'b1, 1'b1, 8'hC1);
    cyc(1'b1, 1'b0, 8'hC2);
    total++; if ({dout0, dout1, dout2} !== 24'h0) begin bad++; $display("FAIL arst_partial got=%h exp=000000", {dout0, dout1, dout2}); end
    cyc(1'b1, 1'b0, 8'hC3);
    total++; if ({frame_vld, dout0, dout1, dout2} !== 25'h1C1C2C3) begin bad++; $display("FAIL arst_frame got=%h exp=1c1c2c3", {frame_vld, dout0, dout1, dout2}); end
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gaps();
    test_sof_error();
    test_exp0_error();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
